// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   - loader_state_t : frame-parser FSM states
//   - field widths for bytes, words, length field and byte index
//   - default frame start marker
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;
    localparam int IDX_W  = 2;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in / instruction-memory write bus out for the boot loader.
//   i_byte, i_byte_valid               : UART receiver byte strobe (no backpressure)
//   o_imem_we, o_imem_addr, o_imem_wdata : one-cycle word write into instruction memory
// master : byte source and memory sink (bench / SoC side)
// slave  : the loader
interface imem_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic [BYTE_W-1:0] i_byte;
    logic              i_byte_valid;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [WORD_W-1:0] o_imem_wdata;

    modport master (
        output i_byte, i_byte_valid,
        input  o_imem_we, o_imem_addr, o_imem_wdata
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_imem_we, o_imem_addr, o_imem_wdata
    );

endinterface

// File: rtl/word_assembler.sv
// Packs four MSB-first bytes into a 32-bit word.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart at byte 0 (frame start)
//   en         : accept byte_data this cycle
//   byte_data  : incoming byte
//   word       : assembled word, valid together with word_done
//   word_done  : high in the cycle the fourth byte is accepted
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [WORD_W-BYTE_W-1:0] shreg;
    logic [IDX_W-1:0]         idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Shift register holds data only; the byte index alone decides validity.
    always_ff @(posedge clk) begin
        if (en) begin
            shreg <= {shreg[WORD_W-2*BYTE_W-1:0], byte_data};
        end
    end

    // The fourth byte is used straight from the input so the word is
    // complete in the same cycle as its last strobe.
    assign word      = {shreg, byte_data};
    assign word_done = en && (&idx);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC / LEN_HI / LEN_LO / 4*N data bytes / CHK from the
// UART byte stream and writes each word into instruction memory at
// consecutive word addresses, holding the CPU in reset while loading.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : byte stream in, instruction-memory write out
//   i_clear        : leave DONE / ERROR back to IDLE
//   o_cpu_hold     : CPU held in reset while high
//   o_done         : image loaded with good checksum
//   o_error        : load failed (length, checksum or timeout)
module imem_loader
    import loader_pkg::*;
#(
    parameter int                DEPTH          = 512,
    parameter int                TIMEOUT_CYCLES = 1_000_000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    imem_loader_if.slave bus,
    input  logic         i_clear,
    output logic         o_cpu_hold,
    output logic         o_done,
    output logic         o_error
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t     state, state_next;
    logic [BYTE_W-1:0] len_hi;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  word_cnt;
    logic [BYTE_W-1:0] xor_acc;
    logic [TO_W-1:0]   timeout_cnt;

    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [WORD_W-1:0] wdata_p1;

    logic              start_frame, acc_xor, write_word;
    logic              asm_en, word_done, in_frame, timeout_hit, last_word;
    logic [WORD_W-1:0] asm_word;
    logic [LEN_W-1:0]  len_in;

    assign in_frame    = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                         (state == ST_DATA)   || (state == ST_CHECK);
    assign asm_en      = bus.i_byte_valid && (state == ST_DATA);
    assign len_in      = {len_hi, bus.i_byte};
    assign last_word   = (word_cnt + CNT_W'(1)) == n_words;
    assign timeout_hit = timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1);

    word_assembler u_asm (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (start_frame),
        .en        (asm_en),
        .byte_data (bus.i_byte),
        .word      (asm_word),
        .word_done (word_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        acc_xor     = 1'b0;
        write_word  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_byte_valid && bus.i_byte == SYNC_BYTE) begin
                    start_frame = 1'b1;
                    state_next  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (bus.i_byte_valid) begin
                    acc_xor    = 1'b1;
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (bus.i_byte_valid) begin
                    acc_xor = 1'b1;
                    if (len_in > LEN_W'(DEPTH)) begin
                        state_next = ST_ERROR;
                    end else if (len_in == '0) begin
                        state_next = ST_CHECK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.i_byte_valid) begin
                    acc_xor = 1'b1;
                    if (word_done) begin
                        write_word = 1'b1;
                        if (last_word) begin
                            state_next = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (bus.i_byte_valid) begin
                    state_next = (bus.i_byte == xor_acc) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                // Clear wins over any byte arriving in the same cycle.
                if (i_clear) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A byte in the expiry cycle keeps the frame alive.
        if (in_frame && !bus.i_byte_valid && timeout_hit) begin
            state_next = ST_ERROR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_hi      <= '0;
            n_words     <= '0;
            word_cnt    <= '0;
            xor_acc     <= '0;
            timeout_cnt <= '0;
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            wdata_p1    <= '0;
        end else begin
            // ---- write stage: registered word, address and strobe ----
            we_p1 <= write_word;
            if (write_word) begin
                addr_p1  <= word_cnt[ADDR_W-1:0];
                wdata_p1 <= asm_word;
                word_cnt <= word_cnt + CNT_W'(1);
            end

            if (start_frame) begin
                xor_acc  <= '0;
                word_cnt <= '0;
            end else if (acc_xor) begin
                xor_acc <= xor_acc ^ bus.i_byte;
            end

            if (state == ST_LEN_HI && bus.i_byte_valid) begin
                len_hi <= bus.i_byte;
            end
            // Only lengths up to DEPTH reach DATA, so the low bits suffice.
            if (state == ST_LEN_LO && bus.i_byte_valid) begin
                n_words <= len_in[CNT_W-1:0];
            end

            if (bus.i_byte_valid || !in_frame) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + TO_W'(1);
            end
        end
    end

    assign bus.o_imem_we    = we_p1;
    assign bus.o_imem_addr  = addr_p1;
    assign bus.o_imem_wdata = wdata_p1;

    // Decoded from the asynchronously reset state, so hold drops with reset.
    assign o_cpu_hold = in_frame || (state == ST_ERROR);
    assign o_done     = (state == ST_DONE);
    assign o_error    = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table of byte strobes with
// expected outputs, plus hand-written sequences for the full-depth image,
// inter-byte timeout and asynchronous reset mid-frame.
module tb_imem_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic hold, done, err;

    imem_loader_if #(.ADDR_W(9)) bus ();

    imem_loader #(
        .DEPTH          (512),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .i_clear    (clear),
        .o_cpu_hold (hold),
        .o_done     (done),
        .o_error    (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write monitor, sampled on the falling edge.
    logic [31:0] mem_model [512];
    logic [8:0]  log_addr  [4096];
    logic [31:0] log_data  [4096];
    int          total_writes = 0;
    int          back_to_back = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (bus.o_imem_we === 1'b1) begin
            mem_model[bus.o_imem_addr] = bus.o_imem_wdata;
            log_addr[total_writes]     = bus.o_imem_addr;
            log_data[total_writes]     = bus.o_imem_wdata;
            total_writes               = total_writes + 1;
            if (prev_we) back_to_back = back_to_back + 1;
        end
        prev_we = (bus.o_imem_we === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        vld;
        logic        clr;
        logic [7:0]  b;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        hold;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic c, input logic [7:0] b,
                       input logic we, input logic [8:0] a, input logic [31:0] d,
                       input logic h, input logic dn, input logic e);
        vec_t r;
        r.vld = v; r.clr = c; r.b = b; r.we = we; r.addr = a; r.wdata = d;
        r.hold = h; r.done = dn; r.err = e;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One strobe, then one idle cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte = b;
        bus.i_byte_valid = 1'b1;
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    function automatic logic [31:0] big_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    initial begin
        logic [7:0]  chk;
        logic [31:0] w;
        int          snap;
        int          bad;

        rst_n = 1'b0;
        clear = 1'b0;
        bus.i_byte = 8'h00;
        bus.i_byte_valid = 1'b0;

        // ---------------- vector table ----------------
        // good 2-word image
        add(1,0,8'hA5, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h00, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h02, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h20, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h10, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h00, 0,9'd0,32'h0,        1,0,0);
        add(1,0,8'h00, 1,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h20, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h05, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h00, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h00, 1,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h17, 0,9'd1,32'h20050000, 0,1,0);
        add(1,0,8'hA5, 0,9'd1,32'h20050000, 0,1,0);   // DONE ignores bytes
        add(0,1,8'h00, 0,9'd1,32'h20050000, 0,0,0);   // clear
        // bad checksum
        add(1,0,8'hA5, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h00, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h02, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h20, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h10, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h00, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h00, 1,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h20, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h05, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h00, 0,9'd0,32'h20100000, 1,0,0);
        add(1,0,8'h00, 1,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h18, 0,9'd1,32'h20050000, 1,0,1);
        add(1,0,8'hA5, 0,9'd1,32'h20050000, 1,0,1);   // ERROR ignores bytes
        add(1,1,8'hA5, 0,9'd1,32'h20050000, 0,0,0);   // clear with SYNC: byte dropped
        // garbage then a 1-word frame, CHK = 00^01^DE^AD^BE^EF = 23
        add(1,0,8'h00, 0,9'd1,32'h20050000, 0,0,0);
        add(1,0,8'hFF, 0,9'd1,32'h20050000, 0,0,0);
        add(1,0,8'h5A, 0,9'd1,32'h20050000, 0,0,0);
        add(1,0,8'hA5, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h00, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'h01, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'hDE, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'hAD, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'hBE, 0,9'd1,32'h20050000, 1,0,0);
        add(1,0,8'hEF, 1,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h23, 0,9'd0,32'hDEADBEEF, 0,1,0);
        add(0,1,8'h00, 0,9'd0,32'hDEADBEEF, 0,0,0);
        // N = 0x0201 > DEPTH
        add(1,0,8'hA5, 0,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h02, 0,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h01, 0,9'd0,32'hDEADBEEF, 1,0,1);
        add(0,1,8'h00, 0,9'd0,32'hDEADBEEF, 0,0,0);
        // N = 0, CHK = 00
        add(1,0,8'hA5, 0,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h00, 0,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h00, 0,9'd0,32'hDEADBEEF, 1,0,0);
        add(1,0,8'h00, 0,9'd0,32'hDEADBEEF, 0,1,0);
        add(0,1,8'h00, 0,9'd0,32'hDEADBEEF, 0,0,0);

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.o_imem_we, bus.o_imem_addr, bus.o_imem_wdata, hold, done, err},
              {1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            bus.i_byte = vecs[i].b;
            bus.i_byte_valid = vecs[i].vld;
            clear = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {bus.o_imem_we, bus.o_imem_addr, bus.o_imem_wdata, hold, done, err},
                  {vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, vecs[i].done, vecs[i].err});
            @(negedge clk);
            bus.i_byte_valid = 1'b0;
            clear = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we_single", i), {63'd0, bus.o_imem_we}, 64'd0);
        end
        check("table_write_count", 64'(total_writes), 64'd5);

        // ---------------- full depth: N = 512 ----------------
        snap = total_writes;
        chk = 8'h02 ^ 8'h00;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 512; i++) begin
            w = big_word(i);
            for (int k = 3; k >= 0; k--) begin
                chk = chk ^ w[k*8 +: 8];
                send_byte(w[k*8 +: 8]);
            end
        end
        send_byte(chk);
        #1;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem_model[i] !== big_word(i)) bad = bad + 1;
        end
        check("n512_writes", 64'(total_writes - snap), 64'd512);
        check("n512_bad_words", 64'(bad), 64'd0);
        check("n512_last_addr", 64'(log_addr[total_writes-1]), 64'd511);
        check("n512_done_hold", {62'd0, done, hold}, {62'd0, 1'b1, 1'b0});
        do_clear();

        // ---------------- timeout after 2 data bytes ----------------
        snap = total_writes;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        @(negedge clk);
        bus.i_byte = 8'h22;
        bus.i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_byte_valid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 99; k++) begin
            @(posedge clk);
            #1;
            if (err !== 1'b0) bad = bad + 1;
        end
        check("timeout_early_error", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        check("timeout_error_at_100", {62'd0, err, hold}, {62'd0, 1'b1, 1'b1});
        check("timeout_no_write", 64'(total_writes - snap), 64'd0);
        do_clear();

        // ---------------- async reset mid-DATA ----------------
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        check("pre_reset_hold", {63'd0, hold}, 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.o_imem_we, bus.o_imem_addr, bus.o_imem_wdata, hold, done, err},
              {1'b0, 9'd0, 32'h0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        snap = total_writes;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h20); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h17);
        check("post_reset_writes", 64'(total_writes - snap), 64'd2);
        check("post_reset_w0", {23'd0, log_addr[snap], log_data[snap]}, {23'd0, 9'd0, 32'h20100000});
        check("post_reset_w1", {23'd0, log_addr[snap+1], log_data[snap+1]}, {23'd0, 9'd1, 32'h20050000});
        check("post_reset_done", {61'd0, done, hold, err}, {61'd0, 1'b1, 1'b0, 1'b0});

        check("we_back_to_back", 64'(back_to_back), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
